// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus arbiter.
//   - lcd_state_e : strobe/arbitration FSM states
//   - LCD_* command constants used by the power-on sequence and wait selection
//   - DEF_T_* default timing values (clk cycles at 20 MHz)
//   - is_long_cmd(): selects the long execution wait for clear/home commands
//   - init_cmd()   : power-on command table (used only when LCD_INIT_EN is defined)
package lcd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StLoad,
    StSetup,
    StEpulse,
    StHold,
    StWait,
    StInitWait
  } lcd_state_e;

  localparam logic [7:0] LCD_CLEAR      = 8'h01;
  localparam logic [7:0] LCD_HOME       = 8'h02;
  localparam logic [7:0] LCD_FUNC_8B2L  = 8'h38;
  localparam logic [7:0] LCD_DISP_ON    = 8'h0C;
  localparam logic [7:0] LCD_ENTRY_INC  = 8'h06;

  localparam int unsigned DEF_T_SETUP      = 2;
  localparam int unsigned DEF_T_EPW        = 10;
  localparam int unsigned DEF_T_HOLD       = 2;
  localparam int unsigned DEF_T_WAIT_SHORT = 800;
  localparam int unsigned DEF_T_WAIT_LONG  = 32800;
  localparam int unsigned DEF_CNT_W        = 16;

  // Power-on delay: 15 ms at 20 MHz, needs its own wider counter.
  localparam int unsigned INIT_WAIT_CYCLES = 300000;
  localparam int unsigned INIT_CNT_W       = 19;

  // Clear (0x01) and home (0x02/0x03, bit 0 is don't-care) take ~1.64 ms to execute.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] db);
    return !rs && ((db == LCD_CLEAR) || (db == LCD_HOME) || (db == 8'h03));
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = LCD_FUNC_8B2L;
      2'd1:    cmd = LCD_DISP_ON;
      2'd2:    cmd = LCD_ENTRY_INC;
      default: cmd = LCD_CLEAR;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Round-robin requester selection for the LCD bus.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (pointer -> 0)
//   req           : per-requester request bits
//   advance       : pulse when the current holder releases the bus
//   advance_from  : index of the releasing holder; pointer moves to advance_from+1 (wrapping)
//   any           : at least one request is pending
//   pick          : first requesting index at or after the pointer (wrapping)
module lcd_rr_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             advance,
  input  logic [IDX_W-1:0] advance_from,
  output logic             any,
  output logic [IDX_W-1:0] pick
);

  logic [IDX_W-1:0] ptr_q;

  always_comb begin
    any  = 1'b0;
    pick = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      automatic int j = int'(ptr_q) + i;
      logic [IDX_W-1:0] jj;
      if (j >= int'(NREQ)) j = j - int'(NREQ);
      jj = IDX_W'(j);
      if (!any && req[jj]) begin
        any  = 1'b1;
        pick = jj;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (advance_from == IDX_W'(NREQ - 1)) ? '0 : advance_from + 1'b1;
    end
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares one character-LCD write bus between NREQ message generators. The bus is granted
// round-robin per message and each byte is strobed onto the LCD with setup/E-pulse/hold
// timing, followed by the controller's execution wait.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req        : per-requester message request (held until the last byte is accepted)
//   gnt        : one-hot registered grant
//   in_valid, in_rs, in_data (8 bits per requester), in_last : per-requester byte stream
//   in_ready   : one-cycle accept pulse for the granted requester's current byte
//   lcd_e, lcd_rs, lcd_rw, lcd_db : LCD pins (write only, lcd_rw tied low)
//   busy       : high whenever the FSM is not idle
// Build option: define LCD_INIT_EN to run the LCD power-on command sequence after reset.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned NREQ         = 2,
  parameter int unsigned T_SETUP      = DEF_T_SETUP,
  parameter int unsigned T_EPW        = DEF_T_EPW,
  parameter int unsigned T_HOLD       = DEF_T_HOLD,
  parameter int unsigned T_WAIT_SHORT = DEF_T_WAIT_SHORT,
  parameter int unsigned T_WAIT_LONG  = DEF_T_WAIT_LONG,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  input  logic [NREQ-1:0]   in_valid,
  input  logic [NREQ-1:0]   in_rs,
  input  logic [8*NREQ-1:0] in_data,
  input  logic [NREQ-1:0]   in_last,
  output logic              in_ready,
  output logic              lcd_e,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic [7:0]        lcd_db,
  output logic              busy
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  lcd_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] g_q;
  logic             last_q;
  logic             arb_any;
  logic [IDX_W-1:0] arb_pick;
  logic             rel_grant;

`ifdef LCD_INIT_EN
  logic [INIT_CNT_W-1:0] init_cnt_q;
  logic [1:0]            init_idx_q;
  logic                  init_active_q;
`endif

  assign lcd_rw = 1'b0;

  // Holder gives up the bus: idle with no byte pending and req dropped, or the end of the
  // post-write wait of its last byte (or of any byte once req has been dropped mid-message).
  always_comb begin
    rel_grant = 1'b0;
    if (state_q == StGrant) begin
      rel_grant = !in_valid[g_q] && !req[g_q];
    end else if (state_q == StWait && cnt_q == '0) begin
      rel_grant = last_q || !req[g_q];
    end
`ifdef LCD_INIT_EN
    if (init_active_q) rel_grant = 1'b0;
`endif
  end

  lcd_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .advance      (rel_grant),
    .advance_from (g_q),
    .any          (arb_any),
    .pick         (arb_pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef LCD_INIT_EN
      state_q       <= StInitWait;
      busy          <= 1'b1;
      init_cnt_q    <= INIT_CNT_W'(INIT_WAIT_CYCLES - 1);
      init_idx_q    <= '0;
      init_active_q <= 1'b1;
`else
      state_q       <= StIdle;
      busy          <= 1'b0;
`endif
      gnt      <= '0;
      in_ready <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_db   <= '0;
      g_q      <= '0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      in_ready <= 1'b0;
      case (state_q)
        StIdle: begin
          if (arb_any) begin
            g_q           <= arb_pick;
            gnt           <= '0;
            gnt[arb_pick] <= 1'b1;
            busy          <= 1'b1;
            state_q       <= StGrant;
          end
        end
        StGrant: begin
          if (in_valid[g_q]) begin
            in_ready <= 1'b1;
            state_q  <= StLoad;
          end else if (rel_grant) begin
            gnt     <= '0;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        // in_ready is high this cycle, so the byte is taken on the edge that leaves LOAD.
        StLoad: begin
          lcd_db  <= in_data[{g_q, 3'b000} +: 8];
          lcd_rs  <= in_rs[g_q];
          last_q  <= in_last[g_q];
          cnt_q   <= CNT_W'(T_SETUP - 1);
          state_q <= StSetup;
        end
        StSetup: begin
          if (cnt_q == '0) begin
            lcd_e   <= 1'b1;
            cnt_q   <= CNT_W'(T_EPW - 1);
            state_q <= StEpulse;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StEpulse: begin
          if (cnt_q == '0) begin
            lcd_e   <= 1'b0;
            cnt_q   <= CNT_W'(T_HOLD - 1);
            state_q <= StHold;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            cnt_q   <= is_long_cmd(lcd_rs, lcd_db) ? CNT_W'(T_WAIT_LONG - 1)
                                                   : CNT_W'(T_WAIT_SHORT - 1);
            state_q <= StWait;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StWait: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
`ifdef LCD_INIT_EN
            if (init_active_q) begin
              if (init_idx_q == 2'd3) begin
                init_active_q <= 1'b0;
                busy          <= 1'b0;
                state_q       <= StIdle;
              end else begin
                init_idx_q <= init_idx_q + 1'b1;
                lcd_db     <= init_cmd(init_idx_q + 1'b1);
                lcd_rs     <= 1'b0;
                cnt_q      <= CNT_W'(T_SETUP - 1);
                state_q    <= StSetup;
              end
            end else
`endif
            if (rel_grant) begin
              gnt     <= '0;
              busy    <= 1'b0;
              state_q <= StIdle;
            end else begin
              state_q <= StGrant;
            end
          end
        end
`ifdef LCD_INIT_EN
        StInitWait: begin
          if (init_cnt_q == '0) begin
            lcd_db  <= init_cmd(2'd0);
            lcd_rs  <= 1'b0;
            cnt_q   <= CNT_W'(T_SETUP - 1);
            state_q <= StSetup;
          end else begin
            init_cnt_q <= init_cnt_q - 1'b1;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
